// File: rtl/lenet5_pkg.sv
// Shared LeNet5 constants: fp32 field positions, classifier sizing and argmax FSM states.
package lenet5_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int NUM_CLASSES   = 10;
  localparam int IDX_BITS      = $clog2(NUM_CLASSES);

  localparam int FP32_SIGN_BIT = 31;
  localparam int FP32_EXP_MSB  = 30;
  localparam int FP32_EXP_LSB  = 23;
  localparam int FP32_MANT_MSB = 22;
  localparam int FP32_MANT_LSB = 0;

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/fp32_greater.sv
// Combinational fp32 "a strictly greater than b" using sign-magnitude ordering.
// Signed zeros compare equal, and a NaN on either side never yields greater.
module fp32_greater
  import lenet5_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  a_gt_b
);

  logic                  a_sign, b_sign;
  logic [FP32_EXP_MSB:0] a_mag, b_mag;
  logic                  a_nan, b_nan;

  assign a_sign = a[FP32_SIGN_BIT];
  assign b_sign = b[FP32_SIGN_BIT];
  assign a_mag  = a[FP32_EXP_MSB:0];
  assign b_mag  = b[FP32_EXP_MSB:0];
  assign a_nan  = (&a[FP32_EXP_MSB:FP32_EXP_LSB]) && (|a[FP32_MANT_MSB:FP32_MANT_LSB]);
  assign b_nan  = (&b[FP32_EXP_MSB:FP32_EXP_LSB]) && (|b[FP32_MANT_MSB:FP32_MANT_LSB]);

  // A NaN best value must never be displaced, so b_nan blocks as well as a_nan.
  always_comb begin
    a_gt_b = 1'b0;
    if (a_nan || b_nan || (a_mag == '0 && b_mag == '0)) begin
      a_gt_b = 1'b0;
    end else if (a_sign != b_sign) begin
      a_gt_b = ~a_sign;
    end else if (!a_sign) begin
      a_gt_b = (a_mag > b_mag);
    end else begin
      a_gt_b = (a_mag < b_mag);
    end
  end

endmodule

// File: rtl/fc2_argmax_classifier.sv
// Final LeNet5 stage: snapshots 10 fp32 FC2 scores on start and serially finds the argmax.
// Build option ARGMAX_SCORE_OUT_EN adds the max_score output carrying the winning value.
module fc2_argmax_classifier
  import lenet5_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] score_in_1,
  input  logic [DATA_WIDTH-1:0] score_in_2,
  input  logic [DATA_WIDTH-1:0] score_in_3,
  input  logic [DATA_WIDTH-1:0] score_in_4,
  input  logic [DATA_WIDTH-1:0] score_in_5,
  input  logic [DATA_WIDTH-1:0] score_in_6,
  input  logic [DATA_WIDTH-1:0] score_in_7,
  input  logic [DATA_WIDTH-1:0] score_in_8,
  input  logic [DATA_WIDTH-1:0] score_in_9,
  input  logic [DATA_WIDTH-1:0] score_in_10,
  output logic                  busy,
  output logic                  done,
`ifdef ARGMAX_SCORE_OUT_EN
  output logic [DATA_WIDTH-1:0] max_score,
`endif
  output logic [IDX_BITS-1:0]   class_out
);

  argmax_state_t         state;
  logic [DATA_WIDTH-1:0] snap [NUM_CLASSES];
  logic [DATA_WIDTH-1:0] best;
  logic [IDX_BITS-1:0]   best_idx;
  logic [IDX_BITS-1:0]   cnt;
  logic [DATA_WIDTH-1:0] cand;
  logic                  cand_gt;
  logic [DATA_WIDTH-1:0] next_best;
  logic [IDX_BITS-1:0]   next_idx;

  always_comb begin
    cand = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (cnt == IDX_BITS'(i)) cand = snap[i];
    end
  end

  fp32_greater u_cmp (
    .a      (cand),
    .b      (best),
    .a_gt_b (cand_gt)
  );

  assign next_best = cand_gt ? cand : best;
  assign next_idx  = cand_gt ? cnt  : best_idx;

  // The final compare result is written straight to the outputs so done lands
  // exactly ten cycles after the accepted start.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      class_out <= '0;
`ifdef ARGMAX_SCORE_OUT_EN
      max_score <= '0;
`endif
      best      <= '0;
      best_idx  <= '0;
      cnt       <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            snap[0]  <= score_in_1;
            snap[1]  <= score_in_2;
            snap[2]  <= score_in_3;
            snap[3]  <= score_in_4;
            snap[4]  <= score_in_5;
            snap[5]  <= score_in_6;
            snap[6]  <= score_in_7;
            snap[7]  <= score_in_8;
            snap[8]  <= score_in_9;
            snap[9]  <= score_in_10;
            best     <= score_in_1;
            best_idx <= '0;
            cnt      <= IDX_BITS'(1);
            busy     <= 1'b1;
            state    <= SCAN;
          end
        end
        SCAN: begin
          best     <= next_best;
          best_idx <= next_idx;
          if (cnt == LAST_IDX) begin
            done      <= 1'b1;
            class_out <= next_idx;
`ifdef ARGMAX_SCORE_OUT_EN
            max_score <= next_best;
`endif
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc2_argmax_classifier.sv
// Testbench for fc2_argmax_classifier: directed table, corner sequences and random vectors.
// Random expectations come from a real-number argmax model; ARGMAX_SCORE_OUT_EN also checks max_score.
module tb_fc2_argmax_classifier;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [9:0][31:0] drv;
  logic             busy;
  logic             done;
  logic [3:0]       class_out;
`ifdef ARGMAX_SCORE_OUT_EN
  logic [31:0]      max_score;
`endif

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string            name;
    logic [9:0][31:0] sc;
    int               exp_idx;
  } vec_t;

  vec_t vecs[8];

  fc2_argmax_classifier dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .score_in_1  (drv[0]),
    .score_in_2  (drv[1]),
    .score_in_3  (drv[2]),
    .score_in_4  (drv[3]),
    .score_in_5  (drv[4]),
    .score_in_6  (drv[5]),
    .score_in_7  (drv[6]),
    .score_in_8  (drv[7]),
    .score_in_9  (drv[8]),
    .score_in_10 (drv[9]),
    .busy        (busy),
    .done        (done),
`ifdef ARGMAX_SCORE_OUT_EN
    .max_score   (max_score),
`endif
    .class_out   (class_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  function automatic bit fp_nan(input logic [31:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  // Plain numeric value of an fp32 pattern; infinities map to huge finite reals.
  function automatic real fp_val(input logic [31:0] v);
    real m;
    int  e;
    e = int'(v[30:23]);
    if (e == 255)    m = 1.0e300;
    else if (e == 0) m = real'(v[22:0]) * (2.0 ** (-149));
    else             m = (1.0 + real'(v[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return v[31] ? -m : m;
  endfunction

  function automatic int ref_argmax(input logic [9:0][31:0] sc);
    int  bi = 0;
    real bv;
    if (fp_nan(sc[0])) return 0;
    bv = fp_val(sc[0]);
    for (int i = 1; i < 10; i++) begin
      if (!fp_nan(sc[i]) && fp_val(sc[i]) > bv) begin
        bi = i;
        bv = fp_val(sc[i]);
      end
    end
    return bi;
  endfunction

  function automatic logic [9:0][31:0] fill(input logic [31:0] rest, input int ia, input logic [31:0] va,
                                             input int ib, input logic [31:0] vb);
    logic [9:0][31:0] r;
    for (int i = 0; i < 10; i++) r[i] = rest;
    r[ia] = va;
    r[ib] = vb;
    return r;
  endfunction

  // One full classification starting in the current cycle; optional noisy inputs and ignored starts.
  task automatic apply_stimulus(input string name, input logic [9:0][31:0] sc, input logic noisy,
                                input logic [3:0] prev_idx, output logic [3:0] got_idx,
                                output logic [31:0] got_score);
    logic [9:0] busy_seen;
    logic [9:0] done_seen;
    got_score = '0;
    got_idx   = '0;
    drv   = sc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      busy_seen[c-1] = busy;
      done_seen[c-1] = done;
      if (c == 5) check_output({name, " class_held"}, 32'(class_out), 32'(prev_idx));
      if (c == 10) begin
        got_idx = class_out;
`ifdef ARGMAX_SCORE_OUT_EN
        got_score = max_score;
`endif
      end
      if (noisy) begin
        for (int k = 0; k < 10; k++) drv[k] = $urandom;
        start = (c == 3 || c == 10);
      end
      tick();
    end
    start = 1'b0;
    check_output({name, " busy_profile"}, 32'(busy_seen), 32'h3FF);
    check_output({name, " done_profile"}, 32'(done_seen), 32'h200);
    check_output({name, " idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic run_and_check(input string name, input logic [9:0][31:0] sc, input int exp_idx,
                               input logic noisy, inout logic [3:0] prev_idx);
    logic [3:0]  idx;
    logic [31:0] score;
    apply_stimulus(name, sc, noisy, prev_idx, idx, score);
    check_output({name, " class_out"}, 32'(idx), 32'(exp_idx));
`ifdef ARGMAX_SCORE_OUT_EN
    check_output({name, " max_score"}, score, sc[exp_idx]);
`endif
    prev_idx = 4'(exp_idx);
  endtask

  function automatic logic [31:0] rand_score();
    logic [31:0] palette [8] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h80000000,
                                 32'h7FC00000, 32'h40400000, 32'hC0400000, 32'h7F800000};
    if ($urandom_range(0, 2) == 0) return palette[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  initial begin
    logic [3:0]       prev;
    logic [9:0][31:0] sc;
    logic [9:0]       done_seen;
    int               exp_idx;

    for (int i = 0; i < 10; i++) vecs[0].sc[i] = 32'h0;
    vecs[0].sc[1] = 32'h3F800000; vecs[0].sc[2] = 32'h40000000; vecs[0].sc[3] = 32'h40400000;
    vecs[0].sc[4] = 32'h40800000; vecs[0].sc[5] = 32'h40A00000; vecs[0].sc[6] = 32'h40C00000;
    vecs[0].sc[7] = 32'h40E00000; vecs[0].sc[8] = 32'h41000000; vecs[0].sc[9] = 32'h41100000;
    vecs[0].name = "ascending";  vecs[0].exp_idx = 9;
    vecs[1] = '{"all_tie",   fill(32'hBFC00000, 0, 32'hBFC00000, 0, 32'hBFC00000), 0};
    vecs[2] = '{"neg_only",  fill(32'hC0400000, 2, 32'hBE800000, 2, 32'hBE800000), 2};
    vecs[3] = '{"sign_mix",  fill(32'hBF800000, 7, 32'h3A83126F, 7, 32'h3A83126F), 7};
    vecs[4] = '{"zeros",     fill(32'hBF800000, 0, 32'h80000000, 4, 32'h00000000), 0};
    vecs[5] = '{"nan_mid",   fill(32'h3F800000, 3, 32'h7FC00000, 5, 32'h40000000), 5};
    vecs[6] = '{"nan_first", fill(32'h40000000, 0, 32'h7FC00000, 0, 32'h7FC00000), 0};
    vecs[7] = '{"tie_pair",  fill(32'h3F800000, 3, 32'h40400000, 6, 32'h40400000), 3};

    reset = 1'b1;
    start = 1'b0;
    drv   = '0;
    repeat (3) tick();
    check_output("reset outputs", {27'd0, busy, done, class_out}, 32'd0);
`ifdef ARGMAX_SCORE_OUT_EN
    check_output("reset max_score", max_score, 32'd0);
`endif
    reset = 1'b0;
    tick();
    prev = 4'd0;

    for (int v = 0; v < 8; v++) run_and_check(vecs[v].name, vecs[v].sc, vecs[v].exp_idx, 1'b0, prev);

    // Busy-time starts with changing inputs are ignored; the back-to-back start is accepted.
    run_and_check("noisy_starts", vecs[5].sc, 5, 1'b1, prev);
    run_and_check("back_to_back", vecs[0].sc, 9, 1'b0, prev);

    // Reset in cycle 5 of a scan aborts without a done pulse.
    drv   = vecs[2].sc;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_output("abort outputs", {27'd0, busy, done, class_out}, 32'd0);
`ifdef ARGMAX_SCORE_OUT_EN
    check_output("abort max_score", max_score, 32'd0);
`endif
    done_seen = '0;
    for (int c = 0; c < 10; c++) begin
      done_seen[c] = done | busy;
      tick();
    end
    check_output("abort quiet", 32'(done_seen), 32'd0);
    prev = 4'd0;
    run_and_check("after_abort", vecs[3].sc, 7, 1'b0, prev);

    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < 10; k++) sc[k] = rand_score();
      exp_idx = ref_argmax(sc);
      run_and_check($sformatf("rand%0d", t), sc, exp_idx, t[0], prev);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
